// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, control-bundle layout and FSM encoding for the pipeline control unit.
package pipe_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARITH     = 7'b0110011;
  localparam logic [6:0] OPC_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OPC_ECALL     = 7'b1110011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;

  localparam int CTRL_W = 10;

  localparam int C_MEM_READ  = 0;
  localparam int C_MEM_TO_REG = 1;
  localparam int C_MEM_WRITE = 2;
  localparam int C_ALU_SRC   = 3;
  localparam int C_REG_WRITE = 4;
  localparam int C_PC_TO_REG = 5;
  localparam int C_IS_ECALL  = 6;
  localparam int C_IS_BRANCH = 7;
  localparam int C_IS_JAL    = 8;
  localparam int C_IS_JALR   = 9;

  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Returns a bundle with only the named field set.
  function automatic ctrl_t ctrl_bit(input int idx);
    ctrl_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational ID-stage decode: opcode -> control bundle plus source-register use flags.
module ctrl_decoder
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter bit CTRL_FLOW_EN = 1'b1
) (
  input  logic [6:0]        opcode,
  input  logic [REG_AW-1:0] rd,
  output logic [CTRL_W-1:0] ctrl,
  output logic              use_rs1,
  output logic              use_rs2,
  output logic              use_ecall_reg
);

  always_comb begin
    ctrl          = '0;
    use_rs1       = 1'b0;
    use_rs2       = 1'b0;
    use_ecall_reg = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        ctrl    = ctrl_bit(C_MEM_READ) | ctrl_bit(C_MEM_TO_REG) |
                  ctrl_bit(C_ALU_SRC) | ctrl_bit(C_REG_WRITE);
        use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        ctrl    = ctrl_bit(C_MEM_WRITE) | ctrl_bit(C_ALU_SRC);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_ARITH: begin
        ctrl    = ctrl_bit(C_REG_WRITE);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_ARITH_IMM: begin
        ctrl    = ctrl_bit(C_ALU_SRC) | ctrl_bit(C_REG_WRITE);
        use_rs1 = 1'b1;
      end
      OPC_ECALL: begin
        ctrl          = ctrl_bit(C_IS_ECALL);
        use_ecall_reg = 1'b1;
      end
      OPC_JAL: begin
        if (CTRL_FLOW_EN) begin
          ctrl = ctrl_bit(C_PC_TO_REG) | ctrl_bit(C_REG_WRITE) | ctrl_bit(C_IS_JAL);
        end
      end
      OPC_JALR: begin
        if (CTRL_FLOW_EN) begin
          ctrl    = ctrl_bit(C_PC_TO_REG) | ctrl_bit(C_REG_WRITE) |
                    ctrl_bit(C_IS_JALR) | ctrl_bit(C_ALU_SRC);
          use_rs1 = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (CTRL_FLOW_EN) begin
          ctrl    = ctrl_bit(C_IS_BRANCH);
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
      end
      default: ;
    endcase
    // x0 is never written, so a write to it must not look like a producer downstream.
    if (rd == '0) begin
      ctrl[C_REG_WRITE] = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_control_unit.sv
// 5-stage pipeline control: decode, ID/EX/MEM/WB control registers, stall/flush and ecall halt.
// Decode reaches ex_ctrl in 1 cycle, mem_ctrl in 2, wb_ctrl in 3; stalls hold PC and IF/ID.
module pipe_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int ECALL_REG    = 17,
  parameter int DRAIN_CYCLES = 3,
  parameter bit CTRL_FLOW_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_halt_cond,
  input  logic              ex_redirect,
  output logic              pc_hold,
  output logic              if_id_hold,
  output logic              if_id_flush,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] mem_rd,
  output logic [REG_AW-1:0] wb_rd,
  output logic              is_halted
);

  localparam int CNT_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [REG_AW-1:0] ECALL_RD = REG_AW'(ECALL_REG);

  logic [CTRL_W-1:0] id_ctrl;
  logic              use_rs1;
  logic              use_rs2;
  logic              use_ecall_reg;
  logic              load_use;
  logic              ecall_stall;
  logic              stall;
  logic              flush;
  logic              id_bubble;
  logic              pipe_clear;
  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;

  ctrl_decoder #(
    .REG_AW       (REG_AW),
    .CTRL_FLOW_EN (CTRL_FLOW_EN)
  ) u_decoder (
    .opcode        (id_opcode),
    .rd            (id_rd),
    .ctrl          (id_ctrl),
    .use_rs1       (use_rs1),
    .use_rs2       (use_rs2),
    .use_ecall_reg (use_ecall_reg)
  );

  always_comb begin
    load_use = ex_ctrl[C_MEM_READ] && (ex_rd != '0) &&
               ((use_rs1 && (ex_rd == id_rs1)) ||
                (use_rs2 && (ex_rd == id_rs2)) ||
                (use_ecall_reg && (ex_rd == ECALL_RD)));
    // ecall reads a7 in ID, so any in-flight producer not yet forwardable must settle first.
    ecall_stall = id_ctrl[C_IS_ECALL] &&
                  ((ex_ctrl[C_REG_WRITE] && (ex_rd == ECALL_RD)) ||
                   (mem_ctrl[C_MEM_READ] && (mem_rd == ECALL_RD)));
    stall = load_use || ecall_stall;
    flush = CTRL_FLOW_EN ? ex_redirect : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    is_halted   = 1'b0;
    id_bubble   = 1'b0;
    pipe_clear  = 1'b0;
    case (state)
      RUN: begin
        if (flush) begin
          if_id_flush = 1'b1;
          id_bubble   = 1'b1;
        end else if (stall) begin
          pc_hold    = 1'b1;
          if_id_hold = 1'b1;
          id_bubble  = 1'b1;
        end else if (id_ctrl[C_IS_ECALL] && id_halt_cond) begin
          state_nxt = DRAIN;
          cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
          id_bubble = 1'b1;
        end
      end
      DRAIN: begin
        pc_hold    = 1'b1;
        if_id_hold = 1'b1;
        id_bubble  = 1'b1;
        if (cnt == '0) begin
          state_nxt = HALTED;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HALTED: begin
        pc_hold    = 1'b1;
        if_id_hold = 1'b1;
        is_halted  = 1'b1;
        id_bubble  = 1'b1;
        pipe_clear = 1'b1;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
    // Outputs read as idle while reset is held, whatever the inputs are doing.
    if (reset) begin
      pc_hold     = 1'b0;
      if_id_hold  = 1'b0;
      if_id_flush = 1'b0;
      is_halted   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_ctrl  <= '0;
      mem_ctrl <= '0;
      wb_ctrl  <= '0;
      ex_rd    <= '0;
      mem_rd   <= '0;
      wb_rd    <= '0;
    end else begin
      ex_ctrl  <= id_bubble  ? '0 : id_ctrl;
      ex_rd    <= id_bubble  ? '0 : id_rd;
      mem_ctrl <= pipe_clear ? '0 : ex_ctrl;
      mem_rd   <= pipe_clear ? '0 : ex_rd;
      wb_ctrl  <= pipe_clear ? '0 : mem_ctrl;
      wb_rd    <= pipe_clear ? '0 : mem_rd;
    end
  end

endmodule
